// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller: ALU control codes,
// controller state encoding and control-code legality check.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_MUL  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    function automatic logic is_legal_ctrl(input logic [3:0] ctrl);
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SLTU,
            ALU_SUB, ALU_SLT, ALU_SRL, ALU_NOR, ALU_MUL: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Combinational 32-bit ALU shared by the controller; wraparound arithmetic,
// shifts operate on b by shamt, unsupported codes produce zero.
module ALU
    import alu_pkg::*;
(
    input  logic [3:0]  ctrl_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  shamt_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = '0;
        case (ctrl_i)
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SLL:  result_o = b_i << shamt_i;
            ALU_SLTU: result_o = {31'b0, a_i < b_i};
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLT:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
            ALU_SRL:  result_o = b_i >> shamt_i;
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_MUL:  result_o = a_i * b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Two-requester sequencing controller around one shared ALU.
// Define ALU_SHARE_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_ctrl,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_shamt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_ctrl,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_shamt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_illegal,
    output logic        busy
);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  ctrl_q;
    logic [31:0] a_q, b_q;
    logic [4:0]  shamt_q;
    logic        id_q;
    logic        rsp_valid_q, rsp_id_q, rsp_zero_q, rsp_illegal_q;
    logic [31:0] rsp_result_q;

    logic        gnt1;
    logic        accept;
    logic [3:0]  sel_ctrl;
    logic [31:0] sel_a, sel_b;
    logic [4:0]  sel_shamt;
    logic [31:0] alu_result;

`ifdef ALU_SHARE_RR_EN
    logic last_q;

    // last_q holds the id granted on the most recent accept; the other side wins a tie
    always_comb gnt1 = req1_valid && (!req0_valid || !last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_q <= 1'b1;
        else if (accept) last_q <= gnt1;
    end
`else
    always_comb gnt1 = req1_valid && !req0_valid;
`endif

    // Ready is gated by rst_n so it reads 0 for the whole time reset is asserted
    always_comb begin
        req0_ready = rst_n && (state_q == IDLE) && req0_valid && !gnt1;
        req1_ready = rst_n && (state_q == IDLE) && gnt1;
        accept     = req0_ready || req1_ready;
        sel_ctrl   = gnt1 ? req1_ctrl  : req0_ctrl;
        sel_a      = gnt1 ? req1_a     : req0_a;
        sel_b      = gnt1 ? req1_b     : req0_b;
        sel_shamt  = gnt1 ? req1_shamt : req0_shamt;
    end

    ALU u_alu (
        .ctrl_i   (ctrl_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .shamt_i  (shamt_q),
        .result_o (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ctrl_q        <= '0;
            a_q           <= '0;
            b_q           <= '0;
            shamt_q       <= '0;
            id_q          <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ctrl_q  <= sel_ctrl;
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        shamt_q <= sel_shamt;
                        id_q    <= gnt1;
                        cnt_q   <= 4'(SETTLE_CYCLES - 1);
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_id_q      <= id_q;
                        rsp_illegal_q <= !is_legal_ctrl(ctrl_q);
                        rsp_result_q  <= is_legal_ctrl(ctrl_q) ? alu_result : '0;
                        rsp_zero_q    <= is_legal_ctrl(ctrl_q) ? (alu_result == '0) : 1'b1;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_illegal = rsp_illegal_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: vector table, arbitration ties,
// backpressure and reset mid-operation, with a response scoreboard.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int unsigned SETTLE = 2;
`ifdef ALU_SHARE_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_shamt, req1_shamt;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_illegal, busy;
    logic [31:0] rsp_result;

    always #5 clk = ~clk;

    alu_share_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .busy(busy)
    );

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        ill;
    } exp_t;

    typedef struct {
        logic        id;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    exp_t sb[$];
    exp_t pend0, pend1;
    vec_t tbl[14];
    int   total = 0;
    int   passed = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endfunction

    // Scoreboard: expectations enter on accept, leave on the response handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (req0_valid && req0_ready) sb.push_back(pend0);
            if (req1_valid && req1_ready) sb.push_back(pend1);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL rsp_unexpected: got response id=%0d result=0x%0h, required none", rsp_id, rsp_result);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
                    check("rsp_result", rsp_result, e.res);
                    check("rsp_zero", {31'b0, rsp_zero}, {31'b0, (e.res == 32'd0)});
                    check("rsp_illegal", {31'b0, rsp_illegal}, {31'b0, e.ill});
                end
            end
        end
    end

    task automatic drive(input logic id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] res, input logic ill);
        if (id) begin
            req1_ctrl = c; req1_a = a; req1_b = b; req1_shamt = sh; req1_valid = 1'b1;
            pend1 = '{id: 1'b1, res: res, ill: ill};
        end else begin
            req0_ctrl = c; req0_a = a; req0_b = b; req0_shamt = sh; req0_valid = 1'b1;
            pend0 = '{id: 1'b0, res: res, ill: ill};
        end
    endtask

    task automatic wait_accept(input logic id, output int n);
        for (n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                @(posedge clk); #1;
                if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
                return;
            end
        end
        total++;
        $display("FAIL accept_timeout: requester %0d never got ready", id);
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_any(output int who);
        who = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                check("one_ready", {31'b0, req0_ready && req1_ready}, 32'd0);
                who = req1_ready ? 1 : 0;
                @(posedge clk); #1;
                if (who == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
                return;
            end
        end
        total++;
        $display("FAIL grant_timeout: no ready, required one");
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 60) begin
            @(posedge clk); #1; n++;
        end
        if (!rsp_valid) begin
            total++;
            $display("FAIL rsp_timeout: rsp_valid stayed 0");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || rsp_valid) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (busy || rsp_valid) begin
            total++;
            $display("FAIL idle_timeout: busy=%0d rsp_valid=%0d, required 0", busy, rsp_valid);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req0_ready"}, {31'b0, req0_ready}, 32'd0);
        check({tag, "_req1_ready"}, {31'b0, req1_ready}, 32'd0);
        check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, "_rsp_id"}, {31'b0, rsp_id}, 32'd0);
        check({tag, "_rsp_result"}, rsp_result, 32'd0);
        check({tag, "_rsp_zero"}, {31'b0, rsp_zero}, 32'd0);
        check({tag, "_rsp_illegal"}, {31'b0, rsp_illegal}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int n, w;
        logic stale;

        tbl[0]  = '{1'b0, ALU_ADD,  32'd4,          32'd1,          5'd0,  32'd5,          1'b0};
        tbl[1]  = '{1'b1, ALU_SUB,  32'd4,          32'd4,          5'd0,  32'd0,          1'b0};
        tbl[2]  = '{1'b0, ALU_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  5'd0,  32'hF000_F000,  1'b0};
        tbl[3]  = '{1'b1, ALU_OR,   32'h0000_00F0,  32'h0000_000F,  5'd0,  32'h0000_00FF,  1'b0};
        tbl[4]  = '{1'b0, ALU_SLL,  32'd0,          32'd1,          5'd3,  32'd8,          1'b0};
        tbl[5]  = '{1'b1, ALU_SRL,  32'd0,          32'h8000_0000,  5'd31, 32'd1,          1'b0};
        tbl[6]  = '{1'b0, ALU_SLT,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd1,          1'b0};
        tbl[7]  = '{1'b1, ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b0};
        tbl[8]  = '{1'b0, ALU_NOR,  32'd0,          32'd0,          5'd0,  32'hFFFF_FFFF,  1'b0};
        tbl[9]  = '{1'b1, ALU_MUL,  32'h0001_0000,  32'h0001_0000,  5'd0,  32'd0,          1'b0};
        tbl[10] = '{1'b0, ALU_MUL,  32'd7,          32'd6,          5'd0,  32'd42,         1'b0};
        tbl[11] = '{1'b1, ALU_ADD,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b0};
        tbl[12] = '{1'b0, 4'b1000,  32'd5,          32'd3,          5'd2,  32'd0,          1'b1};
        tbl[13] = '{1'b1, ALU_SUB,  32'd0,          32'd1,          5'd0,  32'hFFFF_FFFF,  1'b0};

        req0_valid = 1'b0; req0_ctrl = '0; req0_a = '0; req0_b = '0; req0_shamt = '0;
        req1_valid = 1'b0; req1_ctrl = '0; req1_a = '0; req1_b = '0; req1_shamt = '0;
        rsp_ready  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            drive(tbl[i].id, tbl[i].ctrl, tbl[i].a, tbl[i].b, tbl[i].shamt, tbl[i].res, tbl[i].ill);
            wait_accept(tbl[i].id, n);
            wait_rsp(n);
            check($sformatf("latency_v%0d", i), n, SETTLE);
            wait_idle();
        end

        // Tie: req0 wins first; req0 re-raises while req1 still waits
        drive(1'b0, ALU_SUB, 32'd4, 32'd4, 5'd0, 32'd0, 1'b0);
        drive(1'b1, ALU_SLL, 32'd0, 32'd1, 5'd3, 32'd8, 1'b0);
        wait_any(w);
        check("tie1_winner", w, 0);
        drive(1'b0, ALU_ADD, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0);
        wait_any(w);
        check("tie2_winner", w, RR ? 1 : 0);
        wait_any(w);
        check("tie3_winner", w, RR ? 0 : 1);
        wait_idle();

        // Backpressure with a second req0 op waiting
        rsp_ready = 1'b0;
        drive(1'b0, ALU_OR, 32'h12, 32'h21, 5'd0, 32'h33, 1'b0);
        wait_accept(1'b0, n);
        wait_rsp(n);
        drive(1'b0, ALU_ADD, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_result", rsp_result, 32'h33);
            check("bp_req0_ready", {31'b0, req0_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", {31'b0, rsp_valid}, 32'd0);
        wait_accept(1'b0, n);
        check("bp_next_accept", n, 1);
        wait_rsp(n);
        wait_idle();

        // Reset during EXEC
        drive(1'b0, ALU_ADD, 32'd10, 32'd20, 5'd0, 32'd30, 1'b0);
        wait_accept(1'b0, n);
        @(posedge clk); #1;
        check("mid_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            stale = stale | rsp_valid;
        end
        check("no_stale_rsp", {31'b0, stale}, 32'd0);
        drive(1'b0, ALU_ADD, 32'd7, 32'd8, 5'd0, 32'd15, 1'b0);
        wait_accept(1'b0, n);
        wait_rsp(n);
        check("post_rst_latency", n, SETTLE);
        wait_idle();

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
